// File: rtl/snn_inference_controller_if.sv
// Handshake and data bundle between the inference controller, the spike-frame
// source and the two-layer spiking network core.
//   slave  : the controller side (consumes start/abort/frames/net spikes,
//            produces frame_ready, net_* controls, status and results)
//   master : the environment side (frame source + network core + host)
interface snn_inference_controller_if #(
  parameter int M1    = 24,
  parameter int N2    = 8,
  parameter int CLS_W = 3,
  parameter int CNT_W = 8
);
  logic                  start;
  logic                  abort;
  logic                  frame_valid;
  logic [M1-1:0]         frame_data;
  logic                  frame_ready;
  logic                  net_reset;
  logic                  net_enable;
  logic [M1-1:0]         net_input_spikes;
  logic [N2-1:0]         net_output_spikes;
  logic                  busy;
  logic                  done;
  logic                  class_valid;
  logic [CLS_W-1:0]      class_id;
  logic [N2*CNT_W-1:0]   spike_counts;

  modport slave (
    input  start, abort, frame_valid, frame_data, net_output_spikes,
    output frame_ready, net_reset, net_enable, net_input_spikes,
           busy, done, class_valid, class_id, spike_counts
  );

  modport master (
    output start, abort, frame_valid, frame_data, net_output_spikes,
    input  frame_ready, net_reset, net_enable, net_input_spikes,
           busy, done, class_valid, class_id, spike_counts
  );
endinterface

// File: rtl/snn_inference_controller.sv
// Sequences one keyword-spotting inference: pulses net_reset, feeds NUM_STEPS
// frames (each held for STEP_CYCLES enabled clocks), drains DRAIN_CYCLES
// enabled clocks with zero input, counts layer-2 spikes per class with
// saturation, then scans the counts for the argmax (ties -> lowest index).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : controller side of snn_inference_controller_if (start/abort,
//           frame handshake, network controls, busy/done/class results)
module snn_inference_controller #(
  parameter int M1           = 24,
  parameter int N2           = 8,
  parameter int CLS_W        = 3,
  parameter int CNT_W        = 8,
  parameter int STEP_CYCLES  = 4,
  parameter int NUM_STEPS    = 16,
  parameter int DRAIN_CYCLES = 8
) (
  input logic                      clk,
  input logic                      reset,
  snn_inference_controller_if.slave bus
);
  localparam int CYC_MAX = (STEP_CYCLES > DRAIN_CYCLES) ? STEP_CYCLES : DRAIN_CYCLES;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam int STEP_W  = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  localparam logic [CYC_W-1:0]  STEP_LAST  = CYC_W'(STEP_CYCLES - 1);
  localparam logic [CYC_W-1:0]  DRAIN_LAST = CYC_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [CYC_W-1:0]  CYC_ONE    = CYC_W'(1);
  localparam logic [STEP_W-1:0] STEPS_LAST = STEP_W'(NUM_STEPS - 1);
  localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);
  localparam logic [CLS_W-1:0]  IDX_LAST   = CLS_W'(N2 - 1);
  localparam logic [CLS_W-1:0]  IDX_ONE    = CLS_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_FETCH, ST_RUN, ST_DRAIN, ST_DECIDE, ST_DONE
  } state_t;

  state_t             state_r, state_s;
  logic [CYC_W-1:0]   cycle_cnt_r;
  logic [STEP_W-1:0]  step_cnt_r;
  logic [CLS_W-1:0]   idx_r, best_idx_r, class_id_r, cand_idx_s;
  logic [CNT_W-1:0]   best_cnt_r, cand_cnt_s;
  logic [CNT_W-1:0]   count_r [N2];
  logic [M1-1:0]      net_input_spikes_r;
  logic               net_reset_r, done_r, class_valid_r;
  logic               counting_s;

  assign bus.frame_ready      = (state_r == ST_FETCH);
  assign bus.net_enable       = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign bus.busy             = (state_r != ST_IDLE);
  assign bus.net_reset        = net_reset_r;
  assign bus.net_input_spikes = net_input_spikes_r;
  assign bus.done             = done_r;
  assign bus.class_valid      = class_valid_r;
  assign bus.class_id         = class_id_r;
  assign counting_s           = (state_r == ST_RUN) || (state_r == ST_DRAIN);

  for (genvar gi = 0; gi < N2; gi++) begin : g_counts
    assign bus.spike_counts[gi*CNT_W +: CNT_W] = count_r[gi];
  end

  // Argmax candidate after considering class idx_r; idx 0 seeds the scan.
  always_comb begin
    cand_idx_s = best_idx_r;
    cand_cnt_s = best_cnt_r;
    if (idx_r == {CLS_W{1'b0}}) begin
      cand_idx_s = {CLS_W{1'b0}};
      cand_cnt_s = count_r[0];
    end else if (count_r[idx_r] > best_cnt_r) begin
      cand_idx_s = idx_r;
      cand_cnt_s = count_r[idx_r];
    end else begin
      cand_idx_s = best_idx_r;
      cand_cnt_s = best_cnt_r;
    end
  end

  // Next-state decode; abort overrides every transition.
  always_comb begin
    state_s = state_r;
    if (bus.abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   if (bus.start) state_s = ST_CLEAR; else state_s = ST_IDLE;
        ST_CLEAR:  state_s = ST_FETCH;
        ST_FETCH:  if (bus.frame_valid) state_s = ST_RUN; else state_s = ST_FETCH;
        ST_RUN: begin
          if (cycle_cnt_r != STEP_LAST) begin
            state_s = ST_RUN;
          end else if (step_cnt_r != STEPS_LAST) begin
            state_s = ST_FETCH;
          end else if (DRAIN_CYCLES == 0) begin
            state_s = ST_DECIDE;
          end else begin
            state_s = ST_DRAIN;
          end
        end
        ST_DRAIN:  if (cycle_cnt_r == DRAIN_LAST) state_s = ST_DECIDE; else state_s = ST_DRAIN;
        ST_DECIDE: if (idx_r == IDX_LAST) state_s = ST_DONE; else state_s = ST_DECIDE;
        ST_DONE:   state_s = ST_IDLE;
        default:   state_s = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Sequencing counters, network drive and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt_r        <= {CYC_W{1'b0}};
      step_cnt_r         <= {STEP_W{1'b0}};
      net_input_spikes_r <= {M1{1'b0}};
      net_reset_r        <= 1'b0;
      done_r             <= 1'b0;
    end else begin
      net_reset_r <= (state_s == ST_CLEAR);
      done_r      <= (state_s == ST_DONE);

      // cycle_cnt restarts on every entry into RUN or DRAIN
      if ((state_s == state_r) && counting_s) begin
        cycle_cnt_r <= cycle_cnt_r + CYC_ONE;
      end else begin
        cycle_cnt_r <= {CYC_W{1'b0}};
      end

      if (state_s == ST_CLEAR) begin
        step_cnt_r <= {STEP_W{1'b0}};
      end else if ((state_r == ST_RUN) && (cycle_cnt_r == STEP_LAST)) begin
        step_cnt_r <= step_cnt_r + STEP_ONE;
      end else begin
        step_cnt_r <= step_cnt_r;
      end

      // The frame is presented only while in RUN; zero otherwise (incl. abort)
      if ((state_r == ST_FETCH) && (state_s == ST_RUN)) begin
        net_input_spikes_r <= bus.frame_data;
      end else if (state_s == ST_RUN) begin
        net_input_spikes_r <= net_input_spikes_r;
      end else begin
        net_input_spikes_r <= {M1{1'b0}};
      end
    end
  end

  // Per-class saturating spike counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N2; i++) count_r[i] <= {CNT_W{1'b0}};
    end else if (state_s == ST_CLEAR) begin
      for (int i = 0; i < N2; i++) count_r[i] <= {CNT_W{1'b0}};
    end else if (counting_s) begin
      for (int i = 0; i < N2; i++) begin
        if (bus.net_output_spikes[i] && (count_r[i] != CNT_MAX)) begin
          count_r[i] <= count_r[i] + CNT_ONE;
        end else begin
          count_r[i] <= count_r[i];
        end
      end
    end else begin
      for (int i = 0; i < N2; i++) count_r[i] <= count_r[i];
    end
  end

  // Argmax scan registers and the held class result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_r         <= {CLS_W{1'b0}};
      best_idx_r    <= {CLS_W{1'b0}};
      best_cnt_r    <= {CNT_W{1'b0}};
      class_id_r    <= {CLS_W{1'b0}};
      class_valid_r <= 1'b0;
    end else begin
      if (state_r == ST_DECIDE) begin
        idx_r      <= idx_r + IDX_ONE;
        best_idx_r <= cand_idx_s;
        best_cnt_r <= cand_cnt_s;
      end else begin
        idx_r      <= {CLS_W{1'b0}};
        best_idx_r <= best_idx_r;
        best_cnt_r <= best_cnt_r;
      end

      if (state_s == ST_CLEAR) begin
        class_id_r <= {CLS_W{1'b0}};
      end else if (state_s == ST_DONE) begin
        class_id_r <= cand_idx_s;
      end else begin
        class_id_r <= class_id_r;
      end

      if (bus.abort || (state_s == ST_CLEAR)) begin
        class_valid_r <= 1'b0;
      end else if (state_s == ST_DONE) begin
        class_valid_r <= 1'b1;
      end else begin
        class_valid_r <= class_valid_r;
      end
    end
  end
endmodule

// File: doc/snn_inference_controller.md
Name: snn_inference_controller

Overview:
Sequences one keyword-spotting inference on the two-layer spiking network. It clears network state, then feeds NUM_STEPS input spike frames, holding each frame with net_enable high for STEP_CYCLES clocks. It drains in-flight delayed spikes, accumulates per-class output spike counts, and reports the argmax class. It sits between the feature/spike-frame source and the network core.

Parameters:
M1, 24, input spike width (layer-1 inputs)
N2, 8, number of output classes (layer-2 neurons)
CLS_W, 3, width of class index; must satisfy 2^CLS_W >= N2
CNT_W, 8, per-class spike counter width
STEP_CYCLES, 4, clk cycles net_enable is held per timestep (>=1)
NUM_STEPS, 16, input frames per inference (>=1)
DRAIN_CYCLES, 8, enabled cycles with zero input after the last frame (>=0)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin inference; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE from any state
frame_valid  in  1  frame source has a frame
frame_data  in  M1  input spike frame
frame_ready  out  1  controller accepts a frame this cycle
net_reset  out  1  one-cycle pulse that clears network membrane/refractory state
net_enable  out  1  network enable
net_input_spikes  out  M1  spikes presented to the network
net_output_spikes  in  N2  layer-2 output spikes
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at inference completion
class_valid  out  1  class_id is valid; held until the next start or abort
class_id  out  CLS_W  winning class
spike_counts  out  N2*CNT_W  per-class counts; class i at [i*CNT_W +: CNT_W]

Behaviour:
- Reset (async): state=IDLE. All outputs are 0: net_input_spikes=0, spike_counts=0, class_id=0, class_valid=0. step_cnt, cycle_cnt and scan registers are cleared.
- All outputs are registered, except frame_ready, net_enable and busy, which are decoded from state.
- IDLE: on start, go to CLEAR. start while busy is ignored.
- CLEAR (1 cycle): net_reset=1. Clear spike_counts, step_cnt, class_valid, class_id. Go to FETCH.
- FETCH: frame_ready=1, net_enable=0, net_input_spikes=0.
  - On frame_valid & frame_ready: latch frame_data into net_input_spikes, cycle_cnt=0, go to RUN.
  - Stalls indefinitely without a frame; no counting during a stall.
- RUN (STEP_CYCLES cycles): net_enable=1, net_input_spikes holds the frame.
  - On cycle_cnt==STEP_CYCLES-1: step_cnt++.
  - If step_cnt was NUM_STEPS-1, go to DRAIN (or DECIDE if DRAIN_CYCLES=0); otherwise go to FETCH.
- DRAIN (DRAIN_CYCLES cycles): net_enable=1, net_input_spikes=0. Then go to DECIDE.
- Counting: in RUN and DRAIN only, each cycle, for each i with net_output_spikes[i]=1, increment count[i].
  - Counters saturate at 2^CNT_W-1; no wrap.
  - Counts are visible on spike_counts one cycle after the sampling edge.
- DECIDE (N2 cycles): sequential scan, idx 0..N2-1, one per cycle.
  - best starts at index 0 with count[0].
  - A class replaces best only if strictly greater, so ties resolve to the lowest index.
  - After idx N2-1, go to DONE.
- DONE (1 cycle): done=1, class_valid=1, class_id=best. Then go to IDLE. class_id and spike_counts are held in IDLE.
- Latency with frame_valid always high: done is high in cycle 2+NUM_STEPS*(STEP_CYCLES+1)+DRAIN_CYCLES+N2 after the edge that samples start. With defaults this is 98.
- abort (priority over all transitions except reset):
  - Next state is IDLE; net_enable=0, net_input_spikes=0, class_valid=0, no done.
  - spike_counts keep their partial values.
  - abort in IDLE clears class_valid.
- start and abort in the same IDLE cycle: abort wins, remain in IDLE.
- frame_valid outside FETCH is ignored; frame_data is not captured.
- Async reset mid-inference: immediate IDLE, all outputs 0. net_reset is not pulsed; the network shares the system reset.

Test Plan:
- Assert reset mid-RUN -> all outputs 0 asynchronously, busy=0. After release, start begins a fresh inference with net_reset pulse in cycle 1.
- Defaults, frame_valid=1, frames = step index replicated, net_output_spikes=8'b0010_0000 every cycle -> net_input_spikes matches each frame for 4 enabled cycles. spike_counts[5]=72, others 0; class_id=5, class_valid=1; done in cycle 98, exactly 1 cycle wide.
- Drop frame_valid for 10 cycles before step 3 -> frame_ready=1 and net_enable=0 throughout the stall, counts unchanged during the stall, done in cycle 108.
- Drive bits 2 and 6 high every RUN/DRAIN cycle -> counts[2]=counts[6]=72, class_id=2 (lowest-index tie-break).
- CNT_W=4, all output bits high every cycle -> all counts=15 (saturated, no wrap), class_id=0.
- Pulse abort in RUN of step 7 -> IDLE next cycle, busy=0, net_enable=0, no done, class_valid=0. A start during busy earlier in the same run was ignored.
